seq_divider: RTL and testbench

- Sequential restoring divider. It is the inverse of the team's 4x4 combinational multiplier: it takes an 8-bit product-width dividend and a 4-bit divisor, and returns an 8-bit quotient and a 4-bit remainder.
- Iterative shift-subtract core, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath. Used for scaling and for round-trip checks.

---
 rtl/seq_divider_pkg.sv | 22 ++
 rtl/seq_divider_step.sv | 34 +++
 rtl/seq_divider.sv | 143 ++++++++++++++
 tb/tb_seq_divider.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared arithmetic types and widths for the divider
//
// Purpose: state enum, default operand widths and the divide-by-zero quotient
// constant shared by seq_divider, div_step and anything that checks them.
// The default widths match the 4x4 multiplier operand and 8-bit product so the
// divider can undo a multiplication exactly.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_DIVIDEND_W = 8;
  localparam int DIV_DIVISOR_W  = 4;
  localparam int DIV_CNT_W      = 4;

  // Quotient reported for a zero divisor: saturated all ones.
  localparam logic [DIV_DIVIDEND_W-1:0] DIV_DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_step.sv
// rtl/seq_divider_step.sv - one combinational restoring-division iteration
//
// Purpose: shift the next dividend bit into the partial remainder and subtract
// the divisor when it fits.
// Ports:
//   rem_in   partial remainder before the step (DIVISOR_W+1 bits)
//   bit_in   next dividend bit, MSB first
//   divisor  denominator
//   rem_out  partial remainder after the step
//   q_bit    quotient bit produced by this step
module div_step #(
  parameter int DIVISOR_W = seq_divider_pkg::DIV_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted;
  logic               fits;

  always_comb begin
    // The incoming remainder is always below the divisor, so its top bit is
    // zero and the shifted value still fits in DIVISOR_W+1 bits. The top bit
    // is still folded into the compare so a set bit can never be lost.
    shifted = {rem_in[DIVISOR_W-1:0], bit_in};
    fits    = rem_in[DIVISOR_W] | (shifted >= {1'b0, divisor});
    q_bit   = fits;
    rem_out = fits ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider with start/busy/done handshake
//
// Purpose: unsigned DIVIDEND_W / DIVISOR_W division, one quotient bit per clock.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        request, accepted only in IDLE or DONE
//   dividend     numerator, captured on the accept edge
//   divisor      denominator, captured on the accept edge
//   busy         high while iterating
//   done         one-cycle pulse when results are written
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (zero on divide by zero)
//   div_by_zero  registered flag for the last result
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W,
  parameter int CNT_W      = DIV_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  div_state_t            state, state_nxt;
  logic [DIVIDEND_W-1:0] dvd_sh, dvd_nxt;
  logic [DIVISOR_W-1:0]  dvs, dvs_nxt;
  logic [DIVISOR_W:0]    prem, prem_nxt;
  logic [DIVIDEND_W-1:0] quo_sh, quo_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  busy_nxt, done_nxt, dbz_nxt;
  logic [DIVIDEND_W-1:0] q_nxt;
  logic [DIVISOR_W-1:0]  r_nxt;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (prem),
    .bit_in  (dvd_sh[DIVIDEND_W-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_sh      <= '0;
      dvs         <= '0;
      prem        <= '0;
      quo_sh      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      dvd_sh      <= dvd_nxt;
      dvs         <= dvs_nxt;
      prem        <= prem_nxt;
      quo_sh      <= quo_nxt;
      cnt         <= cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      quotient    <= q_nxt;
      remainder   <= r_nxt;
      div_by_zero <= dbz_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dvd_nxt   = dvd_sh;
    dvs_nxt   = dvs;
    prem_nxt  = prem;
    quo_nxt   = quo_sh;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    q_nxt     = quotient;
    r_nxt     = remainder;
    dbz_nxt   = div_by_zero;

    case (state)
      IDLE, DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
        if (start) begin
          if (divisor == '0) begin
            // No iterations needed: report the saturated result right away.
            state_nxt = DONE;
            done_nxt  = 1'b1;
            q_nxt     = '1;
            r_nxt     = '0;
            dbz_nxt   = 1'b1;
          end else begin
            state_nxt = CALC;
            busy_nxt  = 1'b1;
            dvd_nxt   = dividend;
            dvs_nxt   = divisor;
            prem_nxt  = '0;
            quo_nxt   = '0;
            cnt_nxt   = CNT_W'(DIVIDEND_W);
          end
        end
      end

      CALC: begin
        dvd_nxt  = {dvd_sh[DIVIDEND_W-2:0], 1'b0};
        prem_nxt = step_rem;
        quo_nxt  = {quo_sh[DIVIDEND_W-2:0], step_q};
        cnt_nxt  = cnt - CNT_W'(1);
        // Last iteration: publish this step's result directly rather than
        // waiting an extra cycle for the shift registers to settle.
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          q_nxt     = {quo_sh[DIVIDEND_W-2:0], step_q};
          r_nxt     = step_rem[DIVISOR_W-1:0];
          dbz_nxt   = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int checks = 0;
  int failures = 0;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a request is taken whenever no division is pending;
  // a real division finishes 8 edges later with plain / and %.
  int         pend = 0;
  logic [7:0] pq = '0, m_q = '0;
  logic [3:0] pr = '0, m_r = '0;
  bit         m_done = 0, m_busy = 0, m_dbz = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 0; m_q = '0; m_r = '0; m_done = 0; m_busy = 0; m_dbz = 0;
    end else begin
      m_done = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_done = 1; m_q = pq; m_r = pr; m_dbz = 0;
        end
      end else if (start) begin
        if (divisor == 0) begin
          m_done = 1; m_q = DIV_DBZ_QUOTIENT; m_r = 0; m_dbz = 1;
        end else begin
          pq = dividend / divisor;
          pr = dividend % divisor;
          pend = 8;
        end
      end
      m_busy = (pend > 0);
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", busy, m_busy);
    check("cyc_done", done, m_done);
    check("cyc_quotient", quotient, m_q);
    check("cyc_remainder", remainder, m_r);
    check("cyc_dbz", div_by_zero, m_dbz);
  end

  // Issue one request; returns edges from accept to done and busy-cycle count.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = $urandom_range(0, 255); divisor = $urandom_range(0, 15);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
    if (!done) check("timeout", 0, 1);
  endtask

  int lat, bcnt;

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd200, 4'd7, lat, bcnt);
    check("200_7_q", quotient, 28);
    check("200_7_r", remainder, 4);
    check("200_7_dbz", div_by_zero, 0);
    check("200_7_latency", lat, 8);
    check("200_7_busy_cycles", bcnt, 8);
    @(negedge clk);
    check("200_7_done_one_cycle", done, 0);

    run_op(8'd255, 4'd15, lat, bcnt);
    check("255_15_q", quotient, 17);
    check("255_15_r", remainder, 0);
    run_op(8'd5, 4'd9, lat, bcnt);
    check("5_9_q", quotient, 0);
    check("5_9_r", remainder, 5);
    run_op(8'd0, 4'd3, lat, bcnt);
    check("0_3_q", quotient, 0);
    check("0_3_r", remainder, 0);

    run_op(8'd77, 4'd0, lat, bcnt);
    check("dbz_latency", lat, 0);
    check("dbz_q", quotient, 255);
    check("dbz_r", remainder, 0);
    check("dbz_flag", div_by_zero, 1);
    run_op(8'd50, 4'd5, lat, bcnt);
    check("after_dbz_flag", div_by_zero, 0);
    check("after_dbz_q", quotient, 10);

    // Start pulsed mid-iteration must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd99; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("ignore_start_q", quotient, 28);
    check("ignore_start_r", remainder, 4);

    // Start held through DONE: next operation accepted with no idle gap.
    @(negedge clk);
    start = 1'b1; dividend = 8'd255; divisor = 4'd15;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done && lat < 20);
    check("held_first_q", quotient, 17);
    dividend = 8'd100; divisor = 4'd6;
    @(negedge clk);
    start = 1'b0;
    check("held_no_gap_busy", busy, 1);
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("held_second_q", quotient, 16);
    check("held_second_r", remainder, 4);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_q", quotient, 0);
    check("async_rst_r", remainder, 0);
    check("async_rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(8'd100, 4'd6, lat, bcnt);
    check("post_rst_q", quotient, 16);
    check("post_rst_r", remainder, 4);

    // Exhaustive round trip through multiplication.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(a[7:0], b[3:0], lat, bcnt);
        checks++;
        if ((int'(quotient) * b + int'(remainder) != a) || (int'(remainder) >= b)) begin
          failures++;
          $display("FAIL roundtrip %0d/%0d got q=%0d r=%0d", a, b, quotient, remainder);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
